priority_decoder_fifo: RTL

Inverse of the team's 16-input priority encoder. Accepts 8-bit encoder code words (index 0..15, or 0xF0 = "no input active") over a valid/ready handshake. Decodes each code to a 16-bit one-hot vector plus none/error flags and buffers the results in a small first-word-fall-through FIFO. The consumer drains the FIFO over a second valid/ready handshake. Sits downstream of the encoder, e.g. to regenerate line selects on the far side of a narrow 8-bit link.

---
 rtl/priority_decoder_fifo_if.sv | 24 ++
 rtl/priority_decoder_fifo.sv | 95 +++++++++
 2 files changed

// File: rtl/priority_decoder_fifo_if.sv
// Handshake bundle for priority_decoder_fifo: code words in, decoded one-hot entries out.
// The slave modport is the decoder's view; the master modport is the producer/consumer side.
interface priority_decoder_fifo_if #(
    parameter int OUT_W = 16
);
    logic [7:0]       in_code;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_onehot;
    logic             out_none;
    logic             out_error;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_code, in_valid, out_ready,
        output in_ready, out_onehot, out_none, out_error, out_valid
    );

    modport master (
        output in_code, in_valid, out_ready,
        input  in_ready, out_onehot, out_none, out_error, out_valid
    );
endinterface

// File: rtl/priority_decoder_fifo.sv
// Decodes 8-bit priority-encoder code words into one-hot/none/error entries and
// buffers them in a first-word-fall-through FIFO drained over a valid/ready handshake.
module priority_decoder_fifo #(
    parameter int DEPTH = 4,
    parameter int OUT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    priority_decoder_fifo_if.slave  bus,
    output logic [$clog2(DEPTH):0]  fill_count,
    output logic [ERR_W-1:0]        err_count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = OUT_W + 2;

    typedef logic [ENTRY_W-1:0] entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               push, pop;
    logic               out_valid;
    entry_t             in_entry;
    entry_t             head;

    // Entry layout is {error, none, onehot}; only codes with a zero upper nibble index a line.
    always_comb begin
        in_entry = '0;
        if (bus.in_code[7:4] == 4'h0) begin
            in_entry[OUT_W-1:0] = OUT_W'(1) << bus.in_code[3:0];
        end else if (bus.in_code == 8'hF0) begin
            in_entry[OUT_W] = 1'b1;
        end else begin
            in_entry[OUT_W+1] = 1'b1;
        end
    end

    assign bus.in_ready = (fill_q < CNT_W'(DEPTH));
    assign out_valid    = (fill_q != '0);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = out_valid && bus.out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        err_d    = err_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            if (in_entry[OUT_W+1] && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Storage is left unreset; the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            err_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            err_q    <= err_d;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.out_valid  = out_valid;
    assign bus.out_onehot = out_valid ? head[OUT_W-1:0] : '0;
    assign bus.out_none   = out_valid ? head[OUT_W]     : 1'b0;
    assign bus.out_error  = out_valid ? head[OUT_W+1]   : 1'b0;
    assign fill_count     = fill_q;
    assign err_count      = err_q;

endmodule
